// File: rtl/alu_issue_ctrl_if.sv
// Instruction issue channel: valid/ready handshake carrying ALU op and register addresses.
interface alu_issue_ctrl_if #(
    parameter int unsigned SEL_W  = 3,
    parameter int unsigned ADDR_W = 2
);
    logic              valid;
    logic              ready;
    logic [SEL_W-1:0]  op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;

    modport master (output valid, op, rd, rs, rt, input ready);
    modport slave  (input valid, op, rd, rs, rt, output ready);
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/retire sequencer around eightbit_alu: reads operands from a small register file,
// drives the ALU, then writes the result back or reports a taken branch.
module alu_issue_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREG   = 4,
    parameter int unsigned SEL_W  = 3,
    localparam int unsigned ADDR_W = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_ctrl_if.slave   instr,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_f,
    input  logic              alu_ovf,
    input  logic              alu_take_branch,
    output logic              done,
    output logic              branch_taken,
    output logic              ovf_sticky,
    input  logic              ovf_clr,
    output logic [7:0]        retire_cnt
);

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [SEL_W-1:0]  op_q;
    logic [ADDR_W-1:0] rd_q, rs_q, rt_q;
    logic [DATA_W-1:0] f_q;
    logic              ovf_q, br_q;
    logic [DATA_W-1:0] alu_a_q, alu_b_q;
    logic [SEL_W-1:0]  alu_sel_q;
    logic              done_q, branch_taken_q, ovf_sticky_q;
    logic [7:0]        retire_cnt_q;
    logic              accept;

    // A pending load steals the slot, so the source never sees ready while ld_en is high.
    assign instr.ready = !rst && (state_q == StIdle) && !ld_en;
    assign accept      = instr.valid && instr.ready;

    always_comb begin
        rd_data = '0;
        if (rd_addr != '0) rd_data = regs_q[rd_addr];
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_sel      = alu_sel_q;
    assign done         = done_q;
    assign branch_taken = branch_taken_q;
    assign ovf_sticky   = ovf_sticky_q;
    assign retire_cnt   = retire_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            op_q           <= '0;
            rd_q           <= '0;
            rs_q           <= '0;
            rt_q           <= '0;
            f_q            <= '0;
            ovf_q          <= 1'b0;
            br_q           <= 1'b0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_sel_q      <= '0;
            done_q         <= 1'b0;
            branch_taken_q <= 1'b0;
            ovf_sticky_q   <= 1'b0;
            retire_cnt_q   <= '0;
        end else begin
            done_q         <= 1'b0;
            branch_taken_q <= 1'b0;
            // Clear first so a set from WB later in this block wins.
            if (ovf_clr) ovf_sticky_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (ld_en) begin
                        if (ld_addr != '0) regs_q[ld_addr] <= ld_data;
                    end else if (accept) begin
                        op_q    <= instr.op;
                        rd_q    <= instr.rd;
                        rs_q    <= instr.rs;
                        rt_q    <= instr.rt;
                        state_q <= StRead;
                    end
                end
                StRead: begin
                    alu_a_q   <= (rs_q == '0) ? '0 : regs_q[rs_q];
                    alu_b_q   <= (rt_q == '0) ? '0 : regs_q[rt_q];
                    alu_sel_q <= op_q;
                    state_q   <= StExec;
                end
                StExec: begin
                    f_q            <= alu_f;
                    ovf_q          <= alu_ovf;
                    br_q           <= alu_take_branch;
                    done_q         <= 1'b1;
                    branch_taken_q <= alu_take_branch;
                    state_q        <= StWb;
                end
                StWb: begin
                    if (!br_q && (rd_q != '0)) regs_q[rd_q] <= f_q;
                    if (ovf_q) ovf_sticky_q <= 1'b1;
                    retire_cnt_q <= retire_cnt_q + 8'd1;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with an adder-style ALU stub.
module tb_alu_issue_ctrl;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NREG   = 4;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] alu_a, alu_b, alu_f;
    logic [SEL_W-1:0]  alu_sel;
    logic              alu_ovf, alu_take_branch;
    logic              done, branch_taken, ovf_sticky, ovf_clr;
    logic [7:0]        retire_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.SEL_W(SEL_W), .ADDR_W(ADDR_W)) instr ();

    alu_issue_ctrl #(.DATA_W(DATA_W), .NREG(NREG), .SEL_W(SEL_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .instr           (instr),
        .ld_en           (ld_en),
        .ld_addr         (ld_addr),
        .ld_data         (ld_data),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_sel         (alu_sel),
        .alu_f           (alu_f),
        .alu_ovf         (alu_ovf),
        .alu_take_branch (alu_take_branch),
        .done            (done),
        .branch_taken    (branch_taken),
        .ovf_sticky      (ovf_sticky),
        .ovf_clr         (ovf_clr),
        .retire_cnt      (retire_cnt)
    );

    // ALU stub
    always_comb begin
        alu_f           = alu_a + alu_b;
        alu_ovf         = (alu_a[7] == alu_b[7]) && (alu_f[7] != alu_a[7]);
        alu_take_branch = (alu_sel == 3'b111) && (alu_a == alu_b);
    end

    typedef struct {
        string      name;
        logic [7:0] r1;
        logic [7:0] r2;
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [1:0] rt;
        logic [7:0] exp_rd;
        logic       exp_ovf;
        logic       exp_br;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [1:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        check(name, rd_data, exp);
    endtask

    // Returns the cycle (accept cycle = 0) in which done was seen; 8 means it never came.
    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [1:0] rt, output int lat, output logic br);
        instr.op    = op;
        instr.rd    = rd;
        instr.rs    = rs;
        instr.rt    = rt;
        instr.valid = 1'b1;
        tick();
        instr.valid = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        br = branch_taken;
        tick();
    endtask

    task automatic clear_ovf();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic br;
        int   done_seen;
        int   bad;

        vecs[0] = '{"add_basic",   8'h05, 8'hFF, 3'd0, 2'd3, 2'd1, 2'd2, 8'h04, 1'b0, 1'b0};
        vecs[1] = '{"add_ovf",     8'h64, 8'h64, 3'd0, 2'd3, 2'd1, 2'd2, 8'hC8, 1'b1, 1'b0};
        vecs[2] = '{"branch",      8'hAA, 8'hAA, 3'd7, 2'd3, 2'd1, 2'd2, 8'hC8, 1'b1, 1'b1};
        vecs[3] = '{"rd_zero",     8'h05, 8'hFF, 3'd0, 2'd0, 2'd1, 2'd2, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{"rs_rt_rd",    8'h03, 8'h09, 3'd0, 2'd1, 2'd1, 2'd1, 8'h06, 1'b0, 1'b0};
        vecs[5] = '{"sel7_noteq",  8'h01, 8'h02, 3'd7, 2'd3, 2'd1, 2'd2, 8'h03, 1'b0, 1'b0};
        vecs[6] = '{"neg_ovf",     8'h80, 8'hFF, 3'd0, 2'd2, 2'd1, 2'd2, 8'h7F, 1'b1, 1'b0};
        vecs[7] = '{"rt_r0",       8'h10, 8'h44, 3'd0, 2'd3, 2'd1, 2'd0, 8'h10, 1'b0, 1'b0};

        rst         = 1'b1;
        ld_en       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        rd_addr     = '0;
        ovf_clr     = 1'b0;
        instr.valid = 1'b0;
        instr.op    = '0;
        instr.rd    = '0;
        instr.rs    = '0;
        instr.rt    = '0;
        tick();
        tick();
        check("ready_in_reset", instr.ready, 1'b0);
        rst = 1'b0;
        #1;
        check("reset_ready", instr.ready, 1'b1);
        check("reset_retire", retire_cnt, 8'd0);
        check("reset_done", done, 1'b0);
        check("reset_sticky", ovf_sticky, 1'b0);
        check("reset_alu_a", alu_a, 8'd0);
        for (int a = 0; a < 4; a++) check_reg("reset_reg", 2'(a), 8'h00);

        load(2'd0, 8'h55);
        check_reg("ld_r0_ignored", 2'd0, 8'h00);

        // Table-driven instruction vectors
        for (int i = 0; i < 8; i++) begin
            clear_ovf();
            load(2'd1, vecs[i].r1);
            load(2'd2, vecs[i].r2);
            issue(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt, lat, br);
            check({vecs[i].name, "_latency"}, lat, 3);
            check({vecs[i].name, "_branch"}, br, vecs[i].exp_br);
            check_reg({vecs[i].name, "_result"}, vecs[i].rd, vecs[i].exp_rd);
            check({vecs[i].name, "_sticky"}, ovf_sticky, vecs[i].exp_ovf);
            check({vecs[i].name, "_retire"}, retire_cnt, i + 1);
            check({vecs[i].name, "_ready"}, instr.ready, 1'b1);
        end

        // ld_en takes priority over a pending valid
        instr.op    = 3'd0;
        instr.rd    = 2'd3;
        instr.rs    = 2'd1;
        instr.rt    = 2'd2;
        instr.valid = 1'b1;
        ld_en       = 1'b1;
        ld_addr     = 2'd1;
        ld_data     = 8'h22;
        #1;
        check("ld_blocks_ready", instr.ready, 1'b0);
        tick();
        ld_en       = 1'b0;
        instr.valid = 1'b0;
        #1;
        check("ld_no_accept", instr.ready, 1'b1);
        check_reg("ld_priority_data", 2'd1, 8'h22);

        // ld_en while busy is ignored
        load(2'd1, 8'h01);
        load(2'd2, 8'h02);
        instr.valid = 1'b1;
        tick();
        instr.valid = 1'b0;
        ld_en   = 1'b1;
        ld_addr = 2'd2;
        ld_data = 8'h77;
        #1;
        check("busy_not_ready", instr.ready, 1'b0);
        tick();
        ld_en = 1'b0;
        tick();
        check("busy_done", done, 1'b1);
        tick();
        check_reg("busy_ld_ignored", 2'd2, 8'h02);
        check_reg("busy_result", 2'd3, 8'h03);

        // Simultaneous ovf_clr and overflow set: set wins
        clear_ovf();
        load(2'd1, 8'h64);
        load(2'd2, 8'h64);
        instr.valid = 1'b1;
        tick();
        instr.valid = 1'b0;
        tick();
        tick();
        check("setwins_done", done, 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("setwins_sticky", ovf_sticky, 1'b1);
        clear_ovf();
        check("ovf_clr_clears", ovf_sticky, 1'b0);

        // Reset during EXEC abandons the instruction
        load(2'd1, 8'h01);
        load(2'd2, 8'h01);
        load(2'd3, 8'h33);
        instr.valid = 1'b1;
        tick();
        instr.valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("rst_exec_ready", instr.ready, 1'b0);
        done_seen = 0;
        tick();
        if (done === 1'b1) done_seen++;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        check("rst_exec_no_done", done_seen, 0);
        check_reg("rst_exec_dest", 2'd3, 8'h00);
        check("rst_exec_retire", retire_cnt, 8'd0);
        check("rst_exec_idle", instr.ready, 1'b1);

        // retire_cnt wraps after 256 retirements
        bad = 0;
        for (int n = 0; n < 255; n++) begin
            issue(3'd0, 2'd3, 2'd1, 2'd2, lat, br);
            if (lat != 3) bad++;
        end
        check("wrap_latency", bad, 0);
        check("retire_255", retire_cnt, 8'd255);
        issue(3'd0, 2'd3, 2'd1, 2'd2, lat, br);
        check("retire_wrap", retire_cnt, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
